// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads 16-bit program words at pc and presents one- or two-word AVR
// instructions to decode/execute. Define IFETCH_TWO_WORD_EN to assemble JMP/CALL/LDS/STS here.

module instr_fetch #(
    parameter int                  PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] pmem_addr,
    output logic                pmem_rd,
    input  logic [15:0]         pmem_data,
    output logic [15:0]         instr_word1,
    output logic [15:0]         instr_word2,
    output logic                instr_two_word,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc
);

    typedef enum logic [1:0] {F_REQ1, F_CAP1, F_CAP2, F_HOLD} state_t;

    state_t              state, next_state;
    logic [PC_WIDTH-1:0] pc, pc_plus1, pc_plus2;
    logic [15:0]         word1, word2;
    logic                two_word;
    logic                cap_two;
    logic                xfer;

    assign pc_plus1 = pc + PC_WIDTH'(1);
    assign pc_plus2 = pc + PC_WIDTH'(2);
    assign xfer     = (state == F_HOLD) && instr_ready;

`ifdef IFETCH_TWO_WORD_EN
    // JMP/CALL: 1001_010x_xxxx_11xx; LDS/STS: 1001_00xx_xxxx_0000 (decoded on the word being captured)
    assign cap_two = ((pmem_data[15:9] == 7'b1001010) && (pmem_data[3:2] == 2'b11))
                   || ((pmem_data[15:10] == 6'b100100) && (pmem_data[3:0] == 4'b0000));
`else
    assign cap_two = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= F_REQ1;
        else     state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        pmem_rd    = 1'b0;
        pmem_addr  = pc;
        case (state)
            F_REQ1: begin
                pmem_rd    = 1'b1;
                next_state = F_CAP1;
            end
            F_CAP1: begin
                if (cap_two) begin
                    pmem_addr  = pc_plus1;
                    pmem_rd    = 1'b1;
                    next_state = F_CAP2;
                end else begin
                    next_state = F_HOLD;
                end
            end
            F_CAP2:  next_state = F_HOLD;
            F_HOLD:  if (xfer) next_state = F_REQ1;
            default: next_state = F_REQ1;
        endcase
        // Redirect discards whatever is in flight; a read already issued is simply never captured.
        if (redirect) next_state = F_REQ1;
        if (rst)      pmem_rd    = 1'b0;
    end

    // NOTE: holding registers are reset because decode sees them directly and must start at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_VECTOR;
            word1    <= '0;
            word2    <= '0;
            two_word <= 1'b0;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else begin
            case (state)
                F_CAP1: begin
                    word1    <= pmem_data;
                    two_word <= cap_two;
                    if (!cap_two) word2 <= '0;
                end
                F_CAP2: word2 <= pmem_data;
                F_HOLD: if (xfer) pc <= two_word ? pc_plus2 : pc_plus1;
                default: ;
            endcase
        end
    end

    assign instr_word1    = word1;
    assign instr_word2    = word2;
    assign instr_two_word = two_word;
    assign instr_pc       = pc;
    assign instr_valid    = (state == F_HOLD);

endmodule
